// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int XLEN       = 32;
    localparam int INST_BYTES = 4;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/inst_queue.sv
// Small power-of-two FIFO holding fetched instructions with their PCs.
module inst_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [XLEN-1:0]  push_data,
    input  logic [XLEN-1:0]  push_pc,
    input  logic             pop,
    output logic [XLEN-1:0]  head_data,
    output logic [XLEN-1:0]  head_pc,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [XLEN-1:0]  data_q [DEPTH];
    logic [XLEN-1:0]  pc_q   [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en;

    always_comb begin
        wr_en    = push && !flush;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while count is nonzero.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[wr_ptr_q] <= push_data;
            pc_q[wr_ptr_q]   <= push_pc;
        end
    end

    assign head_data = data_q[rd_ptr_q];
    assign head_pc   = pc_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Credit-based instruction fetch with redirect flush and halt drain.
// Define FETCH_BYPASS_EN to let a response reach decode in its arrival cycle.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0,
    parameter int              QUEUE_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            is_idle
);
    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    fetch_state_e     state_q, state_d;
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic [XLEN-1:0]  q_data, q_pc, resp_pc;
    logic [CNT_W-1:0] q_count;
    logic             q_push, q_pop, q_flush;
    logic             run_ok, req_fire, resp_take, resp_retire, bypass, inst_fire;
    logic             unused_redirect_bits;

    assign unused_redirect_bits = ^redirect_pc[1:0];

    // Requests are suppressed during a redirect/halt cycle so the address never
    // changes under a pending request.
    always_comb begin
        run_ok         = !reset && (state_q == RUN) && !halt && !redirect_valid;
        imem_req_valid = run_ok &&
                         (({1'b0, outstanding_q} + {1'b0, q_count}) < SUM_W'(QUEUE_DEPTH));
        imem_req_addr  = fetch_pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        resp_retire    = imem_resp_valid && (outstanding_q != '0);
        resp_take      = run_ok && imem_resp_valid;
        // In RUN every outstanding request is sequential, so the oldest one's PC
        // is recovered from the fetch PC.
        resp_pc        = fetch_pc_q - (XLEN'(outstanding_q) << 2);
`ifdef FETCH_BYPASS_EN
        bypass         = resp_take && (q_count == '0);
`else
        bypass         = 1'b0;
`endif
        inst_valid     = !reset && (state_q == RUN) && ((q_count != '0) || bypass);
        inst           = '0;
        inst_pc        = '0;
        if (inst_valid) begin
            inst    = bypass ? imem_resp_data : q_data;
            inst_pc = bypass ? resp_pc : q_pc;
        end
        inst_fire      = inst_valid && inst_ready;
        q_pop          = inst_fire && !bypass;
        q_push         = resp_take && !(bypass && inst_ready);
        q_flush        = redirect_valid || halt;
        is_idle        = !reset && (state_q == HALTED) && (outstanding_q == '0);
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        drop_d        = drop_q;
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(resp_retire);
        if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(INST_BYTES);
        if ((state_q == FLUSH) && imem_resp_valid) begin
            drop_d = drop_q - CNT_W'(1);
            if (drop_q == CNT_W'(1)) state_d = RUN;
        end
        if (halt) begin
            state_d = HALTED;
            drop_d  = '0;
        end else if (redirect_valid && (state_q != HALTED)) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            drop_d     = outstanding_q - CNT_W'(resp_retire);
            state_d    = (drop_d != '0) ? FLUSH : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    inst_queue #(
        .DEPTH (QUEUE_DEPTH),
        .CNT_W (CNT_W)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (q_flush),
        .push      (q_push),
        .push_data (imem_resp_data),
        .push_pc   (resp_pc),
        .pop       (q_pop),
        .head_data (q_data),
        .head_pc   (q_pc),
        .count     (q_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model plus program-order scoreboard.
module tb_fetch_unit;
    localparam int QD = 2;
    localparam logic [31:0] RST_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        inst_valid, inst_ready = 1'b0;
    logic [31:0] inst, inst_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        is_idle;

    fetch_unit #(.RESET_PC(RST_PC), .QUEUE_DEPTH(QD)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt), .is_idle(is_idle)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Memory model and scoreboard state
    int          cyc = 0;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    int          lat_min = 1, lat_max = 1, ready_pct = 100, iready_pct = 100;
    bit          rand_iready = 0;
    logic [31:0] exp_pc = RST_PC;
    bit          halted_m = 0;
    int          hs_count = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_addr = '0;
    bit          ev_req, ev_hs;
    logic [31:0] ev_req_addr, ev_pc;
    int          ev_pend, ev_cyc;

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;
    vec_t vecs[5];

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h0000_0013;
    endfunction

    task automatic check32(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check1(string name, logic act, logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic step();
        int pend;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (!reset && mq_due.size() > 0 && mq_due[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mq_addr[0]);
        end
        imem_req_ready = ($urandom_range(99) < ready_pct);
        if (rand_iready) inst_ready = ($urandom_range(99) < iready_pct);
        #1;
        ev_req = 0;
        ev_hs  = 0;
        if (!reset) begin
            pend = mq_addr.size();
            if (prev_stall && imem_req_valid) check32("addr_stable", imem_req_addr, prev_addr);
            if (halted_m) begin
                check1("halt_req_valid", imem_req_valid, 1'b0);
                check1("halt_inst_valid", inst_valid, 1'b0);
                check1("halt_is_idle", is_idle, pend == 0);
            end
            if (inst_valid && inst_ready) begin
                check32("inst_pc", inst_pc, exp_pc);
                check32("inst_data", inst, mem_word(exp_pc));
                ev_hs = 1; ev_pc = inst_pc; ev_cyc = cyc;
                exp_pc = exp_pc + 32'd4;
                hs_count++;
            end
            if (imem_resp_valid) begin
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                ev_req = 1; ev_req_addr = imem_req_addr; ev_pend = pend;
                mq_addr.push_back(imem_req_addr);
                mq_due.push_back(cyc + $urandom_range(lat_max, lat_min));
                check1("credit_limit", mq_addr.size() <= QD, 1'b1);
            end
            prev_stall = imem_req_valid && !imem_req_ready;
            prev_addr  = imem_req_addr;
            if (halt) halted_m = 1;
            else if (redirect_valid && !halted_m) exp_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            mq_addr.delete();
            mq_due.delete();
            exp_pc = RST_PC;
            halted_m = 0;
            prev_stall = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(bit chk);
        reset = 1'b1; halt = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0; rand_iready = 0;
        step();
        step();
        if (chk) begin
            check1("rst_req_valid", imem_req_valid, 1'b0);
            check1("rst_inst_valid", inst_valid, 1'b0);
            check1("rst_is_idle", is_idle, 1'b0);
            check32("rst_inst", inst, 32'h0);
            check32("rst_inst_pc", inst_pc, 32'h0);
            check32("rst_fetch_addr", imem_req_addr, RST_PC);
        end
        reset = 1'b0;
        cyc = 0;
    endtask

    // kind 0 waits for a request handshake, kind 1 for an instruction handshake
    task automatic wait_ev(int kind, string name);
        int n = 0;
        do begin
            step();
            n++;
        end while (!((kind == 0) ? ev_req : ev_hs) && n < 40);
        if (!((kind == 0) ? ev_req : ev_hs)) begin
            total++; bad++;
            $display("FAIL %s timeout actual=none required=event", name);
        end
    endtask

    initial begin
        logic [31:0] pcs[4];
        int first_cyc, n, fires, bursts;

        vecs[0] = '{32'h0000_0100, 32'h0000_0100, 32'h0000_0104};
        vecs[1] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104};
        vecs[2] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[3] = '{32'h7FFF_FFFE, 32'h7FFF_FFFC, 32'h8000_0000};
        vecs[4] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0004};

        // Back-to-back fetch from reset with a 1-cycle memory
        do_reset(1);
        lat_min = 1; lat_max = 1; ready_pct = 100; inst_ready = 1'b1;
        n = 0; first_cyc = -1;
        for (int i = 0; i < 40 && n < 4; i++) begin
            step();
            if (ev_hs) begin
                if (first_cyc < 0) first_cyc = ev_cyc;
                pcs[n] = ev_pc;
                n++;
            end
        end
        check32("seq_count", n, 4);
`ifdef FETCH_BYPASS_EN
        check32("first_latency", first_cyc, 1);
`else
        check32("first_latency", first_cyc, 2);
`endif
        for (int i = 0; i < 4; i++) check32("seq_pc", pcs[i], RST_PC + 32'(4 * i));

        // Decode stalled: credits cap requests, nothing lost on release
        do_reset(0);
        inst_ready = 1'b0; fires = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ev_req) fires++;
            check1("stall_no_hs", ev_hs, 1'b0);
        end
        check32("stall_req_count", fires, QD);
        inst_ready = 1'b1; n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            step();
            if (ev_hs) begin
                check32("release_pc", ev_pc, RST_PC + 32'(4 * n));
                n++;
            end
        end
        check32("release_count", n, 4);

        // Redirect with two requests in flight
        for (int v = 0; v < 5; v++) begin
            do_reset(0);
            lat_min = 4; lat_max = 4; inst_ready = 1'b1;
            step();
            step();
            check32("two_outstanding", mq_addr.size(), 2);
            redirect_valid = 1'b1; redirect_pc = vecs[v].rpc;
            step();
            redirect_valid = 1'b0;
            wait_ev(0, "redir_req0");
            check32("redir_addr0", ev_req_addr, vecs[v].exp0);
            check32("redir_flushed", ev_pend, 0);
            wait_ev(0, "redir_req1");
            check32("redir_addr1", ev_req_addr, vecs[v].exp1);
            wait_ev(1, "redir_hs");
            check32("redir_inst_pc", ev_pc, vecs[v].exp0);
        end

        // Halt and redirect together: halt wins, responses drain, then idle
        do_reset(0);
        lat_min = 4; lat_max = 4; inst_ready = 1'b1;
        step();
        step();
        halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
        step();
        halt = 1'b0; redirect_valid = 1'b0;
        fires = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (ev_req) fires++;
        end
        check32("halt_fires", fires, 0);
        check32("halt_drained", mq_addr.size(), 0);
        check1("halt_idle", is_idle, 1'b1);

        // Randomized traffic with random redirects, ending in a halt
        do_reset(0);
        lat_min = 1; lat_max = 3; ready_pct = 60; iready_pct = 70; rand_iready = 1;
        hs_count = 0; bursts = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 3) begin
                redirect_valid = 1'b1;
                redirect_pc = $urandom;
                bursts++;
            end
            step();
            redirect_valid = 1'b0;
        end
        check1("random_progress", hs_count > 200, 1'b1);
        halt = 1'b1;
        step();
        halt = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check1("random_final_idle", is_idle, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-002 SHALL have parameter QUEUE_DEPTH, default 2, instruction queue entries (power of two, 2..8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request to instruction memory.
REQ-006 SHALL have port imem_req_ready  input  1  memory accepts request this cycle.
REQ-007 SHALL have port imem_req_addr  output  32  word-aligned fetch address.
REQ-008 SHALL have port imem_resp_valid  input  1  in-order response, at least 1 cycle after acceptance.
REQ-009 SHALL have port imem_resp_data  input  32  fetched instruction.
REQ-010 SHALL have port inst_valid  output  1  instruction offered to decode.
REQ-011 SHALL have port inst_ready  input  1  decode consumes instruction.
REQ-012 SHALL have ports inst  output  32 and inst_pc  output  32  instruction and its address.
REQ-013 SHALL have ports redirect_valid  input  1 and redirect_pc  input  32  branch/jal/jalr target.
REQ-014 SHALL have port halt  input  1  ecall seen; stop fetching.
REQ-015 SHALL have port is_idle  output  1  halted, no outstanding requests.

Function
REQ-016 SHALL use FSM states RUN, FLUSH, HALTED; reset enters RUN.
REQ-017 RUN: SHALL assert imem_req_valid iff outstanding + queue occupancy < QUEUE_DEPTH; on req handshake fetch_pc += 4 (mod 2^32, wraps).
REQ-018 Responses SHALL enter queue tail tagged with issuing PC; queue SHALL never overflow (guaranteed by REQ-017 credit rule).
REQ-019 inst_valid SHALL equal queue non-empty; pop on inst_valid & inst_ready; inst/inst_pc from head.
REQ-020 redirect_valid SHALL: flush queue same edge, set fetch_pc = {redirect_pc[31:2],2'b00}, set drop counter = outstanding (excluding any response arriving that cycle, which is discarded), enter FLUSH if drop counter nonzero else stay RUN.
REQ-021 FLUSH: SHALL discard each response, decrement drop counter, keep imem_req_valid low; return to RUN when counter reaches 0.
REQ-022 Redirect coincident with inst handshake: handshake SHALL complete; queue flushed afterwards.
REQ-023 halt SHALL enter HALTED, deassert imem_req_valid and inst_valid permanently until reset; responses still drained and discarded.
REQ-024 halt and redirect same cycle: halt SHALL win.
REQ-025 is_idle SHALL be 1 only in HALTED with outstanding == 0.
REQ-026 imem_req_addr SHALL be stable while imem_req_valid & !imem_req_ready.

Reset
REQ-027 On reset: fetch_pc = RESET_PC, queue empty, outstanding = 0, drop = 0, state RUN; imem_req_valid, inst_valid, is_idle = 0; inst, inst_pc = 0.
REQ-028 Reset mid-operation SHALL abandon in-flight requests; the memory is reset by the same signal.

Configuration
REQ-029 FETCH_BYPASS_EN defined: in RUN with queue empty, arriving response SHALL drive inst_valid same cycle and skip the queue if inst_ready=1.
REQ-030 FETCH_BYPASS_EN undefined: responses SHALL always be registered in queue; minimum latency response-to-inst_valid 1 cycle.

Structure
REQ-031 Package fetch_pkg SHALL hold state enum, XLEN=32, INST_BYTES=4, NOP=32'h00000013.
REQ-032 Queue SHALL be sub-module inst_queue (parametric FIFO, data+pc, count output).

Verification
REQ-033 Reset, inst_ready=1, 1-cycle memory -> inst_pc sequence 0,4,8,12 with bypass; one cycle later without.
REQ-034 inst_ready=0 for 10 cycles -> at most QUEUE_DEPTH requests issued, no data lost, order preserved on release.
REQ-035 Two requests outstanding, redirect_pc=32'h100 -> both responses dropped, next inst_pc=32'h100.
REQ-036 redirect_pc=32'h103 -> fetch address 32'h100.
REQ-037 halt and redirect same cycle -> HALTED, no further requests, is_idle=1 after outstanding drains.
REQ-038 fetch_pc=32'hFFFFFFFC -> next fetch address 32'h0.
